// File: rtl/sn76489_multi_cpu_interface_pkg.sv
// Shared definitions for the SN76489 CPU write port: register codes, FSM states, reset values.
package sn76489_multi_cpu_interface_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  typedef enum logic [2:0] {
    REG_FREQ1      = 3'b000,
    REG_FREQ3      = 3'b001,
    REG_FREQ2      = 3'b010,
    REG_NOISE_CTRL = 3'b011,
    REG_ATT1       = 3'b100,
    REG_ATT3       = 3'b101,
    REG_ATT2       = 3'b110,
    REG_ATT_NOISE  = 3'b111
  } reg_code_t;

  localparam logic [3:0] ATT_RESET    = 4'hF;
  localparam logic [7:0] STEREO_RESET = 8'hFF;

  function automatic reg_code_t decode_code(input logic [7:0] d);
    return reg_code_t'({d[3], d[2], d[1]});
  endfunction

  // Latch bytes load the top nibble, data bytes the low six bits.
  function automatic logic [9:0] freq_upd(input logic [9:0] f, input logic [7:0] d, input logic latch);
    return latch ? {d[7:4], f[5:0]} : {f[9:6], d[7:2]};
  endfunction

endpackage

// File: rtl/sn76489_multi_cpu_interface_if.sv
// CPU-side write bus of the PSG port: data, port select, strobes and wait handshake.
interface sn76489_multi_cpu_interface_if #(parameter int NUM_PSG = 1);
  logic [7:0]         d;
  logic               a;
  logic               nWE;
  logic [NUM_PSG-1:0] nCE;
  logic               ready;

  modport master (output d, a, nWE, nCE, input ready);
  modport slave  (input d, a, nWE, nCE, output ready);
endinterface

// File: rtl/sn76489_multi_cpu_interface_reg_bank.sv
// One PSG register bank: latch/data byte decode, tone/att/noise/stereo registers, noise reset strobe.
module sn76489_reg_bank
  import sn76489_multi_cpu_interface_pkg::*;
#(
  parameter int STEREO_EN = 1
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic       i_commit,
  input  logic [7:0] i_d,
  input  logic       i_a,
  output logic [9:0] o_freq1,
  output logic [9:0] o_freq2,
  output logic [9:0] o_freq3,
  output logic [3:0] o_att1,
  output logic [3:0] o_att2,
  output logic [3:0] o_att3,
  output logic [3:0] o_att_noise,
  output logic       o_noise_fb,
  output logic [1:0] o_noise_feed,
  output logic       o_noise_rst,
  output logic [7:0] o_stereo
);
  localparam bit STEREO_ON = (STEREO_EN != 0);

  reg_code_t  r_latched, w_code;
  logic       w_latch, w_psg;
  logic [9:0] r_freq1, r_freq2, r_freq3;
  logic [3:0] r_att1, r_att2, r_att3, r_att_noise;
  logic       r_nfb, r_noise_rst;
  logic [1:0] r_nfeed;
  logic [7:0] r_stereo;

  assign w_latch = i_d[0];
  assign w_psg   = ~(STEREO_ON & i_a);
  assign w_code  = w_latch ? decode_code(i_d) : r_latched;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_latched   <= REG_FREQ1;
      r_freq1     <= '0;
      r_freq2     <= '0;
      r_freq3     <= '0;
      r_att1      <= ATT_RESET;
      r_att2      <= ATT_RESET;
      r_att3      <= ATT_RESET;
      r_att_noise <= ATT_RESET;
      r_nfb       <= 1'b0;
      r_nfeed     <= 2'b00;
      r_noise_rst <= 1'b0;
      r_stereo    <= STEREO_RESET;
    end else begin
      r_noise_rst <= i_commit & w_psg & (w_code == REG_NOISE_CTRL);
      if (i_commit & ~w_psg) r_stereo <= i_d;
      if (i_commit & w_psg) begin
        if (w_latch) r_latched <= w_code;
        case (w_code)
          REG_FREQ1:      r_freq1     <= freq_upd(r_freq1, i_d, w_latch);
          REG_FREQ2:      r_freq2     <= freq_upd(r_freq2, i_d, w_latch);
          REG_FREQ3:      r_freq3     <= freq_upd(r_freq3, i_d, w_latch);
          REG_ATT1:       r_att1      <= i_d[7:4];
          REG_ATT2:       r_att2      <= i_d[7:4];
          REG_ATT3:       r_att3      <= i_d[7:4];
          REG_ATT_NOISE:  r_att_noise <= i_d[7:4];
          REG_NOISE_CTRL: begin
            r_nfeed <= i_d[7:6];
            r_nfb   <= i_d[5];
          end
          default: ;
        endcase
      end
    end
  end

  assign o_freq1      = r_freq1;
  assign o_freq2      = r_freq2;
  assign o_freq3      = r_freq3;
  assign o_att1       = r_att1;
  assign o_att2       = r_att2;
  assign o_att3       = r_att3;
  assign o_att_noise  = r_att_noise;
  assign o_noise_fb   = r_nfb;
  assign o_noise_feed = r_nfeed;
  assign o_noise_rst  = r_noise_rst;
  assign o_stereo     = STEREO_ON ? r_stereo : STEREO_RESET;

endmodule

// File: rtl/sn76489_multi_cpu_interface.sv
// Multi-PSG CPU write port: shared nWE wait FSM and counter, one register bank per chip enable.
module sn76489_multi_cpu_interface
  import sn76489_multi_cpu_interface_pkg::*;
#(
  parameter int NUM_PSG     = 1,
  parameter int WAIT_CYCLES = 32,
  parameter int STEREO_EN   = 1
) (
  input  logic                    clock,
  input  logic                    nReset,
  sn76489_multi_cpu_interface_if.slave bus,
  output logic [NUM_PSG*10-1:0]   freq1,
  output logic [NUM_PSG*10-1:0]   freq2,
  output logic [NUM_PSG*10-1:0]   freq3,
  output logic [NUM_PSG*4-1:0]    att1,
  output logic [NUM_PSG*4-1:0]    att2,
  output logic [NUM_PSG*4-1:0]    att3,
  output logic [NUM_PSG*4-1:0]    attNoise,
  output logic [NUM_PSG-1:0]      noiseFeedback,
  output logic [NUM_PSG*2-1:0]    noiseFeed,
  output logic [NUM_PSG-1:0]      noiseReset,
  output logic [NUM_PSG*8-1:0]    stereo
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_commit, w_wr_low;

  assign w_wr_low = ~(&bus.nCE) & ~bus.nWE;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_wr_low) begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = CW'(1);
      end
      ST_WAIT: begin
        if (!w_wr_low) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_DONE;
          w_commit    = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: if (!w_wr_low) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.ready = (r_state == ST_DONE) | ((r_state == ST_IDLE) & (&bus.nCE));

  // A single commit is broadcast to every bank whose chip enable is low.
  for (genvar gi = 0; gi < NUM_PSG; gi++) begin : g_bank
    sn76489_reg_bank #(.STEREO_EN(STEREO_EN)) u_bank (
      .clock        (clock),
      .nReset       (nReset),
      .i_commit     (w_commit & ~bus.nCE[gi]),
      .i_d          (bus.d),
      .i_a          (bus.a),
      .o_freq1      (freq1[gi*10 +: 10]),
      .o_freq2      (freq2[gi*10 +: 10]),
      .o_freq3      (freq3[gi*10 +: 10]),
      .o_att1       (att1[gi*4 +: 4]),
      .o_att2       (att2[gi*4 +: 4]),
      .o_att3       (att3[gi*4 +: 4]),
      .o_att_noise  (attNoise[gi*4 +: 4]),
      .o_noise_fb   (noiseFeedback[gi]),
      .o_noise_feed (noiseFeed[gi*2 +: 2]),
      .o_noise_rst  (noiseReset[gi]),
      .o_stereo     (stereo[gi*8 +: 8])
    );
  end

endmodule

// File: tb/tb_sn76489_multi_cpu_interface.sv
// Randomized self-checking bench for the multi-PSG write port against a behavioural register model.
module tb_sn76489_multi_cpu_interface;
  localparam int NP = 2;
  localparam int WC = 32;
  localparam int VW = NP * 57;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sn76489_multi_cpu_interface_if #(.NUM_PSG(NP)) bus();

  logic [NP*10-1:0] freq1, freq2, freq3;
  logic [NP*4-1:0]  att1, att2, att3, attNoise;
  logic [NP-1:0]    noiseFeedback, noiseReset;
  logic [NP*2-1:0]  noiseFeed;
  logic [NP*8-1:0]  stereo;
  logic [VW-1:0]    obs;

  sn76489_multi_cpu_interface #(.NUM_PSG(NP), .WAIT_CYCLES(WC), .STEREO_EN(1)) dut (
    .clock(clk), .nReset(rst_n), .bus(bus),
    .freq1(freq1), .freq2(freq2), .freq3(freq3),
    .att1(att1), .att2(att2), .att3(att3), .attNoise(attNoise),
    .noiseFeedback(noiseFeedback), .noiseFeed(noiseFeed),
    .noiseReset(noiseReset), .stereo(stereo)
  );

  assign obs = {freq1, freq2, freq3, att1, att2, att3, attNoise, noiseFeedback, noiseFeed, stereo};

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: plain integer registers per bank; att index 3 is the noise attenuator.
  int m_freq[NP][3];
  int m_att[NP][4];
  int m_nf[NP], m_fb[NP], m_st[NP], m_lat[NP];

  function automatic void model_reset();
    for (int b = 0; b < NP; b++) begin
      for (int c = 0; c < 3; c++) m_freq[b][c] = 0;
      for (int c = 0; c < 4; c++) m_att[b][c] = 15;
      m_nf[b] = 0; m_fb[b] = 0; m_st[b] = 255; m_lat[b] = 0;
    end
  endfunction

  function automatic logic [NP-1:0] model_write(input logic [NP-1:0] ce, input logic a, input logic [7:0] d);
    logic [NP-1:0] pulse;
    int dv, code, ch;
    pulse = '0;
    dv = int'(d);
    for (int b = 0; b < NP; b++) begin
      if (ce[b] == 1'b0) begin
        if (a) m_st[b] = dv;
        else begin
          if (dv % 2 == 1) begin
            code = ((dv >> 3) & 1) * 4 + ((dv >> 2) & 1) * 2 + ((dv >> 1) & 1);
            m_lat[b] = code;
          end else code = m_lat[b];
          case (code)
            0, 2, 1: begin
              ch = (code == 0) ? 0 : (code == 2) ? 1 : 2;
              if (dv % 2 == 1) m_freq[b][ch] = (dv / 16) * 64 + m_freq[b][ch] % 64;
              else             m_freq[b][ch] = (m_freq[b][ch] / 64) * 64 + dv / 4;
            end
            4, 6, 5: begin
              ch = (code == 4) ? 0 : (code == 6) ? 1 : 2;
              m_att[b][ch] = dv / 16;
            end
            7: m_att[b][3] = dv / 16;
            default: begin
              m_nf[b] = dv / 64;
              m_fb[b] = (dv / 32) % 2;
              pulse[b] = 1'b1;
            end
          endcase
        end
      end
    end
    return pulse;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NP*10-1:0] f1, f2, f3;
    logic [NP*4-1:0]  a1, a2, a3, an;
    logic [NP-1:0]    fb;
    logic [NP*2-1:0]  nf;
    logic [NP*8-1:0]  st;
    for (int b = 0; b < NP; b++) begin
      f1[b*10 +: 10] = 10'(m_freq[b][0]);
      f2[b*10 +: 10] = 10'(m_freq[b][1]);
      f3[b*10 +: 10] = 10'(m_freq[b][2]);
      a1[b*4 +: 4] = 4'(m_att[b][0]);
      a2[b*4 +: 4] = 4'(m_att[b][1]);
      a3[b*4 +: 4] = 4'(m_att[b][2]);
      an[b*4 +: 4] = 4'(m_att[b][3]);
      fb[b] = 1'(m_fb[b]);
      nf[b*2 +: 2] = 2'(m_nf[b]);
      st[b*8 +: 8] = 8'(m_st[b]);
    end
    return {f1, f2, f3, a1, a2, a3, an, fb, nf, st};
  endfunction

  // Full write access: nWE low for WC edges, optional extra DONE cycles, then release.
  task automatic do_access(input logic [NP-1:0] ce, input logic a, input logic [7:0] d,
                           input int hold, input string tag);
    logic [NP-1:0] pm;
    pm = '0;
    @(negedge clk);
    bus.nCE = ce; bus.a = a; bus.d = d; bus.nWE = 1'b0;
    for (int k = 1; k <= WC; k++) begin
      @(posedge clk);
      if (k == WC) pm = model_write(ce, a, d);
      @(negedge clk);
      vectors++;
      if (bus.ready !== 1'(k == WC)) begin
        errors++;
        $display("FAIL %s ready@edge%0d got %b want %b", tag, k, bus.ready, k == WC);
      end
    end
    vectors++;
    if (noiseReset !== pm) begin
      errors++; $display("FAIL %s noiseReset pulse got %b want %b", tag, noiseReset, pm);
    end
    vectors++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL %s regs got %h want %h", tag, obs, exp_vec());
    end
    for (int h = 0; h < hold; h++) begin
      bus.d = 8'($urandom);
      @(negedge clk);
      vectors++;
      if (bus.ready !== 1'b1 || noiseReset !== '0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL %s done-hold%0d rdy %b nr %b regs %h want rdy 1 nr 0 regs %h",
                 tag, h, bus.ready, noiseReset, obs, exp_vec());
      end
    end
    bus.nWE = 1'b1; bus.nCE = '1;
    @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b1 || noiseReset !== '0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL %s release rdy %b nr %b regs %h want rdy 1 nr 0 regs %h",
               tag, bus.ready, noiseReset, obs, exp_vec());
    end
  endtask

  task automatic do_abort(input logic [NP-1:0] ce, input logic a, input logic [7:0] d,
                          input int n, input string tag);
    @(negedge clk);
    bus.nCE = ce; bus.a = a; bus.d = d; bus.nWE = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.ready !== 1'b0) begin
        errors++; $display("FAIL %s ready@edge%0d got %b want 0", tag, k, bus.ready);
      end
    end
    bus.nWE = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b0 || noiseReset !== '0) begin
      errors++; $display("FAIL %s aborted rdy %b nr %b want 0 0", tag, bus.ready, noiseReset);
    end
    bus.nCE = '1;
    #1;
    vectors++;
    if (bus.ready !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL %s idle rdy %b regs %h want 1 %h", tag, bus.ready, obs, exp_vec());
    end
  endtask

  task automatic test_reset();
    bus.nCE = '1; bus.nWE = 1'b1; bus.a = 1'b0; bus.d = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (freq1 !== '0 || att1 !== '1 || stereo !== '1 || bus.ready !== 1'b1 || noiseReset !== '0) begin
      errors++;
      $display("FAIL reset f1 %h a1 %h st %h rdy %b nr %b want 0 ff ffff 1 0",
               freq1, att1, stereo, bus.ready, noiseReset);
    end
    vectors++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset regs got %h want %h", obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_handshake();
    @(negedge clk);
    bus.nCE = 2'b10; bus.nWE = 1'b1; bus.a = 1'b0; bus.d = 8'h51;
    @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL handshake ce-only ready got %b want 0", bus.ready);
    end
    do_access(2'b10, 1'b0, 8'h51, 0, "handshake");
  endtask

  task automatic test_latch_data();
    do_access(2'b10, 1'b0, 8'h28, 0, "data_freq1");
    vectors++;
    if (freq1[9:0] !== 10'd330) begin
      errors++; $display("FAIL freq1_330 got %0d want 330", freq1[9:0]);
    end
    do_access(2'b10, 1'b0, 8'h15, 0, "latch_freq2");
    do_access(2'b10, 1'b0, 8'hF0, 1, "data_freq2");
    vectors++;
    if (freq2[9:0] !== 10'd124 || freq1[9:0] !== 10'd330) begin
      errors++; $display("FAIL freq2_124 got %0d/%0d want 124/330", freq2[9:0], freq1[9:0]);
    end
  endtask

  task automatic test_att_noise();
    do_access(2'b10, 1'b0, 8'hA9, 0, "latch_att1");
    vectors++;
    if (att1[3:0] !== 4'hA) begin
      errors++; $display("FAIL att1_A got %h want a", att1[3:0]);
    end
    do_access(2'b10, 1'b0, 8'h50, 0, "data_att1");
    vectors++;
    if (att1[3:0] !== 4'h5) begin
      errors++; $display("FAIL att1_5 got %h want 5", att1[3:0]);
    end
    do_access(2'b10, 1'b0, 8'hA7, 0, "latch_noise");
    vectors++;
    if (noiseFeed[1:0] !== 2'd2 || noiseFeedback[0] !== 1'b1) begin
      errors++; $display("FAIL noise_latch got feed %0d fb %b want 2 1", noiseFeed[1:0], noiseFeedback[0]);
    end
    do_access(2'b10, 1'b0, 8'h20, 2, "data_noise");
    vectors++;
    if (noiseFeed[1:0] !== 2'd0 || noiseFeedback[0] !== 1'b1) begin
      errors++; $display("FAIL noise_data got feed %0d fb %b want 0 1", noiseFeed[1:0], noiseFeedback[0]);
    end
  endtask

  task automatic test_abort();
    do_abort(2'b10, 1'b0, 8'hC1, 10, "abort10");
    do_abort(2'b00, 1'b0, 8'hA7, WC - 1, "abort_last");
    do_access(2'b10, 1'b0, 8'hC1, 0, "after_abort");
  endtask

  task automatic test_multi_stereo();
    do_access(2'b01, 1'b0, 8'hEF, 0, "bank1_attnoise");
    vectors++;
    if (attNoise[7:4] !== 4'hE || attNoise[3:0] !== 4'hF) begin
      errors++; $display("FAIL attNoise_banks got %h want ef", attNoise);
    end
    do_access(2'b00, 1'b1, 8'h5A, 0, "stereo_both");
    vectors++;
    if (stereo !== 16'h5A5A) begin
      errors++; $display("FAIL stereo_both got %h want 5a5a", stereo);
    end
  endtask

  task automatic test_back_to_back();
    do_access(2'b00, 1'b0, 8'h37, 3, "b2b_noise");
    do_access(2'b00, 1'b0, 8'hFC, 3, "b2b_data");
    do_access(2'b01, 1'b0, 8'h0B, 0, "b2b_latch");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    bus.nCE = 2'b00; bus.a = 1'b0; bus.d = 8'h51; bus.nWE = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs !== exp_vec() || noiseReset !== '0) begin
      errors++; $display("FAIL reset_mid_wait regs %h nr %b want %h 0", obs, noiseReset, exp_vec());
    end
    bus.nCE = '1; bus.nWE = 1'b1;
    #1;
    vectors++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_wait ready got %b want 1", bus.ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_access(2'b00, 1'b0, 8'h9B, 0, "post_reset");
  endtask

  task automatic test_random();
    logic [NP-1:0] ce;
    logic [7:0] d;
    logic a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: ce = 2'b00;
        1: ce = 2'b01;
        default: ce = 2'b10;
      endcase
      a = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) do_abort(ce, a, d, $urandom_range(1, WC - 1), "rnd_abort");
      else do_access(ce, a, d, $urandom_range(0, 3), "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_latch_data();
    test_att_noise();
    test_abort();
    test_multi_stereo();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
